// File: rtl/bcedn_unpool.sv
// bcedn_unpool: decoder-side max-unpooling.
// Takes pooled D-bit pixels one at a time in raster order. For each pixel it reads WPP
// pool-index words from the encoder's index SRAM, then emits the upsampled map in raster order.
// Each channel bit lands at its recorded window position, and every other position is 0.
// Output row 0 of each window row is emitted per pixel (EMIT0). Rows 1..POOL_H-1 are parked
// in a line buffer and streamed out after the last pixel of the row (EMIT_BUF).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle pulse that begins a frame (ignored unless idle)
//   in_en/in_ready  pixel handshake; a pixel transfers when both are high
//   data_in         pooled pixel, MSB = channel 0
//   pindex_rd       index SRAM read strobe
//   pindex_rd_addr  index SRAM read address
//   pindex_in       index SRAM read data, valid one cycle after the strobe
//   data_out/out_en unpooled output pixel and its valid
//   done            one-cycle pulse after the last output pixel of a frame
//   nn_mode         (only with BCEDN_UNPOOL_NN_EN) nearest-neighbour upsampling, latched on start
//
// Optional feature macro: BCEDN_UNPOOL_NN_EN.
module bcedn_unpool #(
  parameter int unsigned H_IN   = 16,
  parameter int unsigned W_IN   = 64,
  parameter int unsigned D      = 512,
  parameter int unsigned POOL_H = 2,
  parameter int unsigned POOL_W = 2,
  parameter int unsigned N_PE   = 1,
  localparam int unsigned IW = (POOL_H * POOL_W > 1) ? $clog2(POOL_H * POOL_W) : 1,
  localparam int unsigned PINDEX_WIDTH = IW * N_PE,
  localparam int unsigned WPP = D / N_PE,
  localparam int unsigned INDEX_ADDR_WIDTH =
      (H_IN * W_IN * WPP > 1) ? $clog2(H_IN * W_IN * WPP) : 1
) (
`ifdef BCEDN_UNPOOL_NN_EN
  input  logic                        nn_mode,
`endif
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_en,
  output logic                        in_ready,
  input  logic [D-1:0]                data_in,
  output logic                        pindex_rd,
  output logic [INDEX_ADDR_WIDTH-1:0] pindex_rd_addr,
  input  logic [PINDEX_WIDTH-1:0]     pindex_in,
  output logic [D-1:0]                data_out,
  output logic                        out_en,
  output logic                        done
);

  localparam int unsigned RW  = (H_IN > 1) ? $clog2(H_IN) : 1;
  localparam int unsigned CW  = (W_IN > 1) ? $clog2(W_IN) : 1;
  localparam int unsigned FW  = $clog2(WPP + 1);
  localparam int unsigned DCW = (POOL_W > 1) ? $clog2(POOL_W) : 1;
  localparam int unsigned BRW = (POOL_H > 2) ? $clog2(POOL_H - 1) : 1;
  localparam int unsigned LBW = (POOL_H > 1) ? (POOL_H - 1) * POOL_W * D : D;
  localparam int unsigned AW  = INDEX_ADDR_WIDTH;

  typedef enum logic [2:0] {StIdle, StWaitPx, StFetch, StEmit0, StEmitBuf} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   px_row_q, px_row_d;
  logic [CW-1:0]   px_col_q, px_col_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [DCW-1:0]  dc_q, dc_d;
  logic [BRW-1:0]  br_q, br_d;
  logic [CW-1:0]   bc_q, bc_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [D-1:0]    data_q, data_d;
  logic [D*IW-1:0] idx_q, idx_d;  // channel c index at [c*IW +: IW]
  logic            done_q, done_d;
  logic            nn_active;
  logic            lbuf_we;
  logic [LBW-1:0]  lbuf_wdata, lbuf_rd;

`ifdef BCEDN_UNPOOL_NN_EN
  logic nn_q, nn_d;
  assign nn_active = nn_q;
`else
  assign nn_active = 1'b0;
`endif

  // Window pattern for one position: keep a channel bit only where its index points here.
  // Indices >= POOL_H*POOL_W never match any position, so such channels stay 0.
  function automatic logic [D-1:0] pat(input logic [D-1:0] data, input logic [D*IW-1:0] idx,
                                       input logic [IW-1:0] pos, input logic nn);
    logic [D-1:0] r;
    r = '0;
    for (int c = 0; c < D; c++) begin
      if (nn || idx[c*IW +: IW] == pos) r[D-1-c] = data[D-1-c];
    end
    return r;
  endfunction

  always_comb begin
    lbuf_wdata = '0;
    for (int dr = 1; dr < POOL_H; dr++) begin
      for (int dc = 0; dc < POOL_W; dc++) begin
        lbuf_wdata[((dr - 1) * POOL_W + dc) * D +: D] =
            pat(data_q, idx_q, IW'(dr * POOL_W + dc), nn_active);
      end
    end
  end

  if (POOL_H > 1) begin : g_lbuf
    // Every entry is rewritten each pixel row before it is read, so no clear is needed.
    logic [LBW-1:0] lbuf_q [W_IN];
    always_ff @(posedge clk) begin
      if (lbuf_we) lbuf_q[px_col_q] <= lbuf_wdata;
    end
    assign lbuf_rd = lbuf_q[bc_q];
  end else begin : g_no_lbuf
    assign lbuf_rd = '0;
  end

  always_comb begin
    state_d   = state_q;
    px_row_d  = px_row_q;
    px_col_d  = px_col_q;
    fcnt_d    = fcnt_q;
    dc_d      = dc_q;
    br_d      = br_q;
    bc_d      = bc_q;
    addr_d    = addr_q;
    data_d    = data_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    lbuf_we   = 1'b0;
    in_ready  = 1'b0;
    pindex_rd = 1'b0;
    out_en    = 1'b0;
    data_out  = '0;
`ifdef BCEDN_UNPOOL_NN_EN
    nn_d      = nn_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StWaitPx;
          px_row_d = '0;
          px_col_d = '0;
          fcnt_d   = '0;
          dc_d     = '0;
          br_d     = '0;
          bc_d     = '0;
          addr_d   = '0;
`ifdef BCEDN_UNPOOL_NN_EN
          nn_d     = nn_mode;
`endif
        end
      end
      StWaitPx: begin
        in_ready = 1'b1;
        if (in_en) begin
          data_d  = data_in;
          fcnt_d  = '0;
          dc_d    = '0;
          state_d = nn_active ? StEmit0 : StFetch;
        end
      end
      StFetch: begin
        // Strobes on fcnt 0..WPP-1; word fcnt-1 arrives on fcnt 1..WPP. The address runs
        // continuously across pixels, which matches word p*WPP+k in raster order.
        if (fcnt_q < FW'(WPP)) begin
          pindex_rd = 1'b1;
          addr_d    = addr_q + AW'(1);
        end
        for (int k = 0; k < WPP; k++) begin
          if (int'(fcnt_q) == k + 1) begin
            for (int i = 0; i < N_PE; i++) begin
              idx_d[(i * WPP + k) * IW +: IW] = pindex_in[PINDEX_WIDTH - 1 - i * IW -: IW];
            end
          end
        end
        if (fcnt_q == FW'(WPP)) state_d = StEmit0;
        else                    fcnt_d  = fcnt_q + FW'(1);
      end
      StEmit0: begin
        out_en   = 1'b1;
        data_out = pat(data_q, idx_q, IW'(dc_q), nn_active);
        lbuf_we  = (POOL_H > 1) && (dc_q == '0);
        if (dc_q == DCW'(POOL_W - 1)) begin
          dc_d = '0;
          if (px_col_q != CW'(W_IN - 1)) begin
            px_col_d = px_col_q + CW'(1);
            state_d  = StWaitPx;
          end else if (POOL_H > 1) begin
            br_d    = '0;
            bc_d    = '0;
            state_d = StEmitBuf;
          end else if (px_row_q != RW'(H_IN - 1)) begin
            px_row_d = px_row_q + RW'(1);
            px_col_d = '0;
            state_d  = StWaitPx;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end else begin
          dc_d = dc_q + DCW'(1);
        end
      end
      StEmitBuf: begin
        out_en   = 1'b1;
        data_out = lbuf_rd[(int'(br_q) * int'(POOL_W) + int'(dc_q)) * int'(D) +: D];
        if (dc_q != DCW'(POOL_W - 1)) begin
          dc_d = dc_q + DCW'(1);
        end else begin
          dc_d = '0;
          if (bc_q != CW'(W_IN - 1)) begin
            bc_d = bc_q + CW'(1);
          end else begin
            bc_d = '0;
            if (br_q != BRW'(POOL_H - 2)) begin
              br_d = br_q + BRW'(1);
            end else begin
              px_col_d = '0;
              if (px_row_q != RW'(H_IN - 1)) begin
                px_row_d = px_row_q + RW'(1);
                state_d  = StWaitPx;
              end else begin
                done_d  = 1'b1;
                state_d = StIdle;
              end
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      px_row_q <= '0;
      px_col_q <= '0;
      fcnt_q   <= '0;
      dc_q     <= '0;
      br_q     <= '0;
      bc_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
`ifdef BCEDN_UNPOOL_NN_EN
      nn_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      px_row_q <= px_row_d;
      px_col_q <= px_col_d;
      fcnt_q   <= fcnt_d;
      dc_q     <= dc_d;
      br_q     <= br_d;
      bc_q     <= bc_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
`ifdef BCEDN_UNPOOL_NN_EN
      nn_q     <= nn_d;
`endif
    end
  end

  assign pindex_rd_addr = addr_q;
  assign done           = done_q;

endmodule

// File: doc/bcedn_unpool.md
Name: bcedn_unpool

Overview:
- Decoder-side max-unpooling block; counterpart of the binary conv encoder's pooling stage.
- Accepts pooled binary feature vectors one pixel at a time.
- For each pixel, reads that pixel's pool-index words back from the encoder's index SRAM.
- Emits the upsampled (H_IN*POOL_H x W_IN*POOL_W) map in raster order. Each channel bit is placed at its recorded window position; all other window positions are 0. Output feeds the decoder conv input shift register.

Parameters:
- H_IN, 16, pooled map height (rows of input pixels).
- W_IN, 64, pooled map width.
- D, 512, channels per pixel (data_in/data_out width).
- POOL_H, 2, pooling window height.
- POOL_W, 2, pooling window width.
- N_PE, 1, index fields packed per SRAM word; D divisible by N_PE.
- Derived: IW = max(1, clog2(POOL_H*POOL_W)).
- Derived: PINDEX_WIDTH = IW*N_PE.
- Derived: WPP = D/N_PE (index words per pixel).
- Derived: INDEX_ADDR_WIDTH = clog2(H_IN*W_IN*WPP).

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset, asynchronous, active-high.
- start, in, 1, one-cycle pulse that begins a frame.
- in_en, in, 1, data_in valid.
- in_ready, out, 1, block can take a pixel this cycle.
- data_in, in, D, pooled pixel; MSB = channel 0.
- pindex_rd, out, 1, index SRAM read strobe.
- pindex_rd_addr, out, INDEX_ADDR_WIDTH, index SRAM read address.
- pindex_in, in, PINDEX_WIDTH, index SRAM read data, valid 1 cycle after strobe.
- data_out, out, D, unpooled output pixel.
- out_en, out, 1, data_out valid.
- done, out, 1, one-cycle pulse after the last output pixel of the frame.

Behaviour:
- Reset (async, any state): FSM to IDLE; in_ready, pindex_rd, out_en, done = 0; data_out, pindex_rd_addr, all counters = 0.
- Transfer rule: a pixel is consumed only when in_en && in_ready. in_en without in_ready is ignored and must be held by the source.
- Index encoding: idx = dr*POOL_W + dc, where (dr, dc) is the position inside the window.
- Word packing: in word k of a pixel, field i (MSB-first, IW bits) is the index of channel i*WPP + k.
- Word address: pixel p (raster order, 0..H_IN*W_IN-1) uses words p*WPP + k, k = 0..WPP-1.
- Output bit rule: window position (dr, dc), channel c: out bit = data bit c AND (idx[c] == dr*POOL_W + dc).

State machine:
- IDLE:
  - start -> WAIT_PX, counters cleared.
  - start while not IDLE is ignored.
- WAIT_PX:
  - in_ready = 1.
  - On transfer: latch data_in, go to FETCH.
- FETCH:
  - pindex_rd = 1 for WPP consecutive cycles with ascending addresses.
  - Each pindex_in word is captured the cycle after its strobe.
  - After the last capture (WPP+1 cycles after entering), go to EMIT0.
- EMIT0:
  - POOL_W cycles with out_en = 1, dc = 0..POOL_W-1, dr = 0.
  - Simultaneously write the dr = 1..POOL_H-1 patterns into line-buffer entry [px_col].
  - Next: px_col < W_IN-1 -> WAIT_PX with px_col+1; otherwise -> EMIT_BUF.
- EMIT_BUF:
  - For dr = 1..POOL_H-1, emit W_IN*POOL_W pixels back-to-back from the line buffer, out_en = 1 every cycle.
  - Then: px_row < H_IN-1 -> WAIT_PX with px_row+1, px_col = 0; otherwise pulse done, go to IDLE.
- Line buffer: W_IN entries x (POOL_H-1)*POOL_W*D bits. Fully overwritten every pixel row, so no clear is needed. With POOL_H = 1 it is absent and EMIT_BUF is skipped.
- Latency: first out_en occurs WPP+2 cycles after the first transfer.
- Frame length: exactly H_IN*W_IN*POOL_H*POOL_W out_en cycles per frame.
- out_en is never asserted in IDLE, WAIT_PX or FETCH.
- Out-of-range indices (value >= POOL_H*POOL_W) yield 0 for that channel at every position.

Optional Feature:
- Macro: BCEDN_UNPOOL_NN_EN.
- Defined:
  - Adds input port nn_mode (1 bit), sampled on start and held for the frame.
  - nn_mode = 1: FETCH is skipped (WAIT_PX -> EMIT0 directly, pindex_rd stays 0), and every window position replicates data_in (nearest-neighbour upsampling).
  - nn_mode = 0: identical to baseline.
- Undefined: port absent; baseline behaviour only.

Test Plan:
- Test parameters for all scenarios: H_IN=2, W_IN=2, D=4, N_PE=2, POOL 2x2.
- Reset: assert rst mid-FETCH -> all outputs 0 immediately; IDLE; no out_en until the next start.
- Single pixel, indices {0,1,2,3}, data_in = 4'b1111:
  - Required pindex_rd addresses 0, 1, for pixel 0.
  - Row 0 outputs 1000, 0100.
  - Row 1 (from buffer) outputs 0010, 0001.
- Full frame, random data and indices: exactly 16 out_en cycles, raster order matches the golden model; done pulses once, one cycle after the 16th out_en.
- Input stall: hold in_en low 5 cycles between pixels -> no out_en gaps within EMIT0 bursts; no data loss; in_ready is high only in WAIT_PX.
- Index 3 for all channels, data_in = 4'b1010 -> positions 0–2 output 0000, position 3 outputs 1010.
- With BCEDN_UNPOOL_NN_EN defined and nn_mode = 1 -> pindex_rd never asserted; all 4 window positions equal data_in; first out_en 1 cycle after transfer.
